// File: rtl/uart_rx_bit_timer_if.sv
// Bundle between the receiver FSM (master) and the UART RX bit-timing engine (slave).
// Latency: none; this only groups the wires.
// Backpressure: none; start/abort are single-cycle commands and the timer outputs are strobes.
// Optional cfg_err wire exists only when UART_RX_TIMER_ERR_EN is defined.
interface uart_rx_bit_timer_if #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
);

  // Control from the receiver FSM and the start-edge detector.
  logic                  start;
  logic                  abort;
  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  stop2;

  // Timing status and strobes back to the sampler and deserializer.
  logic                  busy;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  sample_strb;
  logic [1:0]            sample_idx;
  logic                  bit_end;
  logic                  frame_end;
`ifdef UART_RX_TIMER_ERR_EN
  logic                  cfg_err;
`endif

  modport master (
    output start,
    output abort,
    output prescale,
    output par_en,
    output stop2,
    input  busy,
    input  edge_cnt,
    input  bit_cnt,
    input  sample_strb,
    input  sample_idx,
    input  bit_end,
    input  frame_end
`ifdef UART_RX_TIMER_ERR_EN
    , input cfg_err
`endif
  );

  modport slave (
    input  start,
    input  abort,
    input  prescale,
    input  par_en,
    input  stop2,
    output busy,
    output edge_cnt,
    output bit_cnt,
    output sample_strb,
    output sample_idx,
    output bit_end,
    output frame_end
`ifdef UART_RX_TIMER_ERR_EN
    , output cfg_err
`endif
  );

endinterface

// File: rtl/uart_rx_bit_timer.sv
// UART RX bit-timing engine: edge/bit counters, 3-point sample strobes, bit/frame end pulses.
// Latency: busy rises the cycle after start; strobes are combinational from the counters.
// Backpressure: none; start is ignored while running, abort wins over everything.
// Optional: define UART_RX_TIMER_ERR_EN to reject prescale<4 with a one-cycle cfg_err pulse
// instead of clamping it to 4.
module uart_rx_bit_timer #(
  parameter int PRESCALE_W = 6,
  parameter int DATA_W     = 8,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_rx_bit_timer_if.slave     tmr_if
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Smallest oversampling ratio that still leaves room for three distinct sample edges.
  localparam logic [PRESCALE_W-1:0] P_MIN     = PRESCALE_W'(4);
  // Index of the last bit with one stop bit and no parity: start + data bits.
  localparam logic [BIT_CNT_W-1:0]  LAST_BASE = BIT_CNT_W'(DATA_W + 1);

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;

  logic                  run;
  logic                  cfg_bad;
  logic                  start_go;
  logic [PRESCALE_W-1:0] p_sel;
  logic [PRESCALE_W-1:0] p_m1;
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] mid_m1;
  logic [PRESCALE_W-1:0] mid_p1;
  logic [BIT_CNT_W-1:0]  last_bit;
  logic                  at_bit_end;
  logic                  at_last_bit;
  logic                  strb;
  logic [1:0]            idx;

  assign run         = (state_q == RUN);
  assign cfg_bad     = (tmr_if.prescale < P_MIN);
  assign p_sel       = cfg_bad ? P_MIN : tmr_if.prescale;

  // Derived timing points, all kept at counter width; legal P keeps them in range.
  assign p_m1        = p_q - PRESCALE_W'(1);
  assign mid         = p_q >> 1;
  assign mid_m1      = mid - PRESCALE_W'(1);
  assign mid_p1      = mid + PRESCALE_W'(1);
  assign last_bit    = LAST_BASE + BIT_CNT_W'(par_en_q) + BIT_CNT_W'(stop2_q);
  assign at_bit_end  = (edge_q == p_m1);
  assign at_last_bit = (bit_q == last_bit);

  // A frame may only be launched from IDLE and never in the same cycle as an abort.
`ifdef UART_RX_TIMER_ERR_EN
  assign start_go = (state_q == IDLE) && tmr_if.start && !tmr_if.abort && !cfg_bad;
`else
  assign start_go = (state_q == IDLE) && tmr_if.start && !tmr_if.abort;
`endif

  // State, counters and latched frame configuration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      edge_q   <= '0;
      bit_q    <= '0;
      p_q      <= P_MIN;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      edge_q   <= edge_d;
      bit_q    <= bit_d;
      p_q      <= p_d;
      par_en_q <= par_en_d;
      stop2_q  <= stop2_d;
    end
  end

  // Next-state logic: launch, count edges/bits, finish or abort the frame.
  always_comb begin
    state_d  = state_q;
    edge_d   = edge_q;
    bit_d    = bit_q;
    p_d      = p_q;
    par_en_d = par_en_q;
    stop2_d  = stop2_q;

    if (tmr_if.abort) begin
      state_d = IDLE;
      edge_d  = '0;
      bit_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          edge_d = '0;
          bit_d  = '0;
          if (start_go) begin
            // The start cycle itself is edge 0 of bit 0, so RUN begins on edge 1.
            state_d  = RUN;
            edge_d   = PRESCALE_W'(1);
            p_d      = p_sel;
            par_en_d = tmr_if.par_en;
            stop2_d  = tmr_if.stop2;
          end
        end
        RUN: begin
          if (at_bit_end) begin
            edge_d = '0;
            if (at_last_bit) begin
              state_d = IDLE;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + BIT_CNT_W'(1);
            end
          end else begin
            edge_d = edge_q + PRESCALE_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          edge_d  = '0;
          bit_d   = '0;
        end
      endcase
    end
  end

  // Majority-vote sample strobes around the bit centre, for every bit of the frame.
  always_comb begin
    strb = 1'b0;
    idx  = 2'd0;
    if (run) begin
      if (edge_q == mid_m1) begin
        strb = 1'b1;
        idx  = 2'd0;
      end else if (edge_q == mid) begin
        strb = 1'b1;
        idx  = 2'd1;
      end else if (edge_q == mid_p1) begin
        strb = 1'b1;
        idx  = 2'd2;
      end
    end
  end

`ifdef UART_RX_TIMER_ERR_EN
  logic cfg_err_q, cfg_err_d;

  assign cfg_err_d = (state_q == IDLE) && tmr_if.start && !tmr_if.abort && cfg_bad;

  // One-cycle flag for a start request carrying an unusable prescale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign tmr_if.cfg_err = cfg_err_q;
`endif

  assign tmr_if.busy        = run;
  assign tmr_if.edge_cnt    = edge_q;
  assign tmr_if.bit_cnt     = bit_q;
  assign tmr_if.sample_strb = strb;
  assign tmr_if.sample_idx  = idx;
  // An aborted frame must not report a bit or frame boundary, even on its last edge.
  assign tmr_if.bit_end     = run && at_bit_end && !tmr_if.abort;
  assign tmr_if.frame_end   = run && at_bit_end && at_last_bit && !tmr_if.abort;

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Bench for uart_rx_bit_timer: directed frames plus randomized frames against a frame-offset model.
// Latency: outputs sampled 1 time unit after the falling edge, inputs driven on the falling edge.
// Backpressure: none; abort, spurious start and async reset are injected directly.
module tb_uart_rx_bit_timer;

  localparam int PW = 6;
  localparam int BW = 4;
  localparam int DW = 8;

  logic clk;
  logic rst;

  uart_rx_bit_timer_if #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) bus ();

  uart_rx_bit_timer #(.PRESCALE_W(PW), .DATA_W(DW), .BIT_CNT_W(BW)) dut (
    .clk    (clk),
    .rst    (rst),
    .tmr_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fe_cyc   = -1;

  // Reference model: a running frame is described by its offset k from the start cycle.
  bit m_run  = 1'b0;
  int m_k    = 0;
  int m_p    = 4;
  int m_last = 9;
  bit m_err  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic a);
    int pos, bitn, mid, e_strb, e_idx, e_be, e_fe;
    pos    = m_run ? (m_k % m_p) : 0;
    bitn   = m_run ? (m_k / m_p) : 0;
    mid    = m_p / 2;
    e_strb = (m_run && pos >= mid - 1 && pos <= mid + 1) ? 1 : 0;
    e_idx  = e_strb ? (pos - (mid - 1)) : 0;
    e_be   = (m_run && pos == m_p - 1 && !a) ? 1 : 0;
    e_fe   = (e_be && bitn == m_last) ? 1 : 0;
    chk("busy",        32'(bus.busy),        32'(m_run));
    chk("edge_cnt",    32'(bus.edge_cnt),    32'(pos));
    chk("bit_cnt",     32'(bus.bit_cnt),     32'(bitn));
    chk("sample_strb", 32'(bus.sample_strb), 32'(e_strb));
    chk("sample_idx",  32'(bus.sample_idx),  32'(e_idx));
    chk("bit_end",     32'(bus.bit_end),     32'(e_be));
    chk("frame_end",   32'(bus.frame_end),   32'(e_fe));
`ifdef UART_RX_TIMER_ERR_EN
    chk("cfg_err",     32'(bus.cfg_err),     32'(m_err));
`endif
    if (bus.frame_end === 1'b1 && fe_cyc < 0) fe_cyc = cyc;
  endtask

  // Advance the model by one clock given the inputs seen during the cycle.
  task automatic model_update(input logic s, input logic a, input int ps, input logic pe, input logic s2);
    m_err = 1'b0;
    if (a) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (s) begin
`ifdef UART_RX_TIMER_ERR_EN
        if (ps < 4) begin
          m_err = 1'b1;
        end else begin
          m_run = 1'b1; m_k = 1; m_p = ps; m_last = DW + 1 + int'(pe) + int'(s2);
        end
`else
        m_run = 1'b1; m_k = 1; m_p = (ps < 4) ? 4 : ps; m_last = DW + 1 + int'(pe) + int'(s2);
`endif
      end
    end else if (m_k == (m_last + 1) * m_p - 1) begin
      m_run = 1'b0;
    end else begin
      m_k++;
    end
  endtask

  task automatic step(input logic s, input logic a, input int ps, input logic pe, input logic s2);
    @(negedge clk);
    bus.start    = s;
    bus.abort    = a;
    bus.prescale = PW'(ps);
    bus.par_en   = pe;
    bus.stop2    = s2;
    #1;
    check_outputs(a);
    model_update(s, a, ps, pe, s2);
    cyc++;
  endtask

  task automatic quiet(input int n, input int ps);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, ps, 1'b0, 1'b0);
  endtask

  task automatic begin_frame(input int ps, input logic pe, input logic s2);
    cyc    = 0;
    fe_cyc = -1;
    step(1'b1, 1'b0, ps, pe, s2);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    m_run = 1'b0;
    m_err = 1'b0;
    check_outputs(1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int ps, gap, len;
    logic pe, s2, s, a;

    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.prescale = '0;
    bus.par_en   = 1'b0;
    bus.stop2    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_outputs(1'b0);
    @(negedge clk);
    rst = 1'b1;
    quiet(2, 0);

    // P=8, 8N1: bit ends every 8 clocks, frame end at cycle 79, idle from 80.
    begin_frame(8, 1'b0, 1'b0);
    quiet(84, 8);
    chk("fe_cycle_p8", 32'(fe_cyc), 32'd79);

    // P=16, parity and two stop bits: LAST=11, frame end at 191.
    begin_frame(16, 1'b1, 1'b1);
    quiet(196, 16);
    chk("fe_cycle_p16_par_stop2", 32'(fe_cyc), 32'd191);

    // Odd prescale P=5: centre is edge 2, frame end at 49.
    begin_frame(5, 1'b0, 1'b0);
    quiet(54, 5);
    chk("fe_cycle_p5", 32'(fe_cyc), 32'd49);

    // Abort together with a start at cycle 20: no frame end, then a clean full frame.
    begin_frame(8, 1'b0, 1'b0);
    quiet(19, 8);
    step(1'b1, 1'b1, 8, 1'b0, 1'b0);
    quiet(100, 8);
    chk("abort_no_frame_end", 32'(fe_cyc), 32'hFFFF_FFFF);
    begin_frame(8, 1'b0, 1'b0);
    quiet(84, 8);
    chk("fe_cycle_after_abort", 32'(fe_cyc), 32'd79);

    // Re-pulsed start with new config at cycle 30 does not disturb timing.
    begin_frame(8, 1'b0, 1'b0);
    quiet(29, 8);
    step(1'b1, 1'b0, 32, 1'b1, 1'b1);
    quiet(54, 32);
    chk("fe_cycle_restart_ignored", 32'(fe_cyc), 32'd79);

    // Asynchronous reset in the middle of a frame.
    begin_frame(8, 1'b0, 1'b0);
    quiet(39, 8);
    async_reset();
    quiet(3, 8);

    // Illegal prescale=2.
    begin_frame(2, 1'b0, 1'b0);
    quiet(44, 2);
`ifdef UART_RX_TIMER_ERR_EN
    chk("fe_cycle_bad_prescale", 32'(fe_cyc), 32'hFFFF_FFFF);
`else
    chk("fe_cycle_clamped_p4", 32'(fe_cyc), 32'd39);
`endif

    // Randomized frames with spurious starts, config churn and rare aborts.
    for (int f = 0; f < 30; f++) begin
      ps  = int'($urandom_range(4, 20));
      pe  = 1'($urandom_range(0, 1));
      s2  = 1'($urandom_range(0, 1));
      gap = int'($urandom_range(0, 3));
      for (int i = 0; i < gap; i++) step(1'b0, 1'b0, int'($urandom_range(0, 63)), 1'b0, 1'b0);
      begin_frame(ps, pe, s2);
      len = (DW + 2 + int'(pe) + int'(s2)) * ps + 1;
      for (int i = 0; i < len; i++) begin
        s = ($urandom_range(0, 9) == 0) && m_run;
        a = ($urandom_range(0, 299) == 0);
        step(s, a, int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      quiet(1, 8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_bit_timer.md
Name: uart_rx_bit_timer

Overview:
Parametrised bit-timing engine for the UART receiver. Replaces the fixed edge/bit counter pair. Adds configurable data width, optional 2 stop bits and a run/idle state machine with start/abort control. It emits a 3-point majority-vote sample strobe, bit-end and frame-end pulses. It sits between the start-bit detector and the sampler/deserializer inside uartRX, and is driven by the receiver FSM.

Parameters:
PRESCALE_W, 6, width of prescale and edge_cnt; legal prescale values are 4..2^PRESCALE_W-1.
DATA_W, 8, data bits per frame (5..9).
BIT_CNT_W, 4, width of bit_cnt; must satisfy 2^BIT_CNT_W > DATA_W+3.

Ports:
clk  in  1  system clock (oversampling clock)
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse from the start-edge detector; the start cycle counts as edge 0 of bit 0
abort  in  1  synchronous abort of the current frame (e.g. start glitch)
prescale  in  PRESCALE_W  oversampling ratio (clocks per bit), latched at start
par_en  in  1  parity bit present, latched at start
stop2  in  1  two stop bits, latched at start
busy  out  1  high while a frame is being timed
edge_cnt  out  PRESCALE_W  clock index within the current bit, 0..P-1
bit_cnt  out  BIT_CNT_W  bit index: 0 = start, 1..DATA_W = data, then parity (if enabled), then stop bit(s)
sample_strb  out  1  high on the 3 majority-vote sample edges
sample_idx  out  2  0/1/2 = first/second/third sample; 0 when sample_strb is low
bit_end  out  1  pulse on the last edge of each bit
frame_end  out  1  pulse on the last edge of the last bit

Behaviour:
- Reset: busy=0, edge_cnt=0, bit_cnt=0, sample_strb=0, sample_idx=0, bit_end=0, frame_end=0. Latched config is cleared to P=4, par_en=0, stop2=0.
- States: IDLE and RUN.
- IDLE: counters are held at 0. On start=1 (and abort=0):
  - latch P=prescale, par_en and stop2;
  - load edge_cnt=1 and bit_cnt=0;
  - go to RUN and set busy=1 in the next cycle.
- RUN: each clock increments edge_cnt. When edge_cnt==P-1, edge_cnt wraps to 0 and bit_cnt increments.
- LAST = DATA_W + 1 + par_en + stop2 (latched values). With DATA_W=8, no parity, one stop bit: LAST=9, 10 bits total.
- Frame end: edge_cnt==P-1 with bit_cnt==LAST. frame_end=1 that cycle, and the next state is IDLE with edge_cnt=0 and bit_cnt=0.
- Frame length: frame_end occurs exactly (LAST+1)*P-1 cycles after the start cycle.
- Samples: M=P>>1. sample_strb is high combinationally while in RUN and edge_cnt is M-1, M or M+1, with sample_idx 0, 1, 2 respectively. These fire for every bit, including bit 0.
- bit_end is combinational: RUN && edge_cnt==P-1. frame_end is bit_end && bit_cnt==LAST.
- start while in RUN is ignored. Mid-frame changes to prescale, par_en or stop2 have no effect.
- abort (RUN or IDLE, highest priority, also over start): next cycle is IDLE with counters 0. No bit_end or frame_end is issued for the aborted frame.
- Illegal prescale: a value <4 at start is clamped to P=4.
- Arithmetic: every compare is at PRESCALE_W width. P-1 and M+1 never overflow for legal P.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous).

Optional Feature:
Macro UART_RX_TIMER_ERR_EN.
- Defined: adds output cfg_err (1 bit, registered, reset 0). When start arrives with prescale<4, the block stays in IDLE, pulses cfg_err=1 for one cycle and does not latch the config.
- Not defined: no cfg_err port; prescale<4 is clamped to 4 as described above.

Test Plan:
- P=8, DATA_W=8, par_en=0, stop2=0, start at cycle 0 -> bit_end at cycles 7, 15, ..., 79; sample_strb at edge_cnt 3, 4, 5 of each bit; frame_end at cycle 79; busy=0 from cycle 80.
- P=16, par_en=1, stop2=1 -> LAST=11; frame_end at cycle 191; bit_cnt sequence 0..11 with no skip.
- P=5 (odd) -> M=2; samples at edge_cnt 1, 2, 3 with idx 0, 1, 2; frame_end at cycle 49.
- P=8, abort asserted at cycle 20 together with start -> next cycle IDLE with counters 0; no frame_end; the following start pulse times a full frame.
- P=8, prescale changed to 32 and start re-pulsed at cycle 30 -> timing unchanged and frame_end at 79. rst asserted low at cycle 40 -> all outputs 0 immediately.
- prescale=2 at start -> clamped to P=4 and frame_end at cycle 39 (macro off); with UART_RX_TIMER_ERR_EN, cfg_err pulses 1 cycle and busy stays 0.
